// File: rtl/sobel_result_writer.sv
// Sobel result sink: clears the frame buffer, writes interior pixels in raster order
// as they arrive on the bus, and exposes a read-first synchronous read port.
module sobel_result_writer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_out,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic              frame_start,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count
);

    localparam int                NPIX     = IMG_W * IMG_H;
    localparam logic [ADDR_W:0]   NPIX_A   = (ADDR_W+1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACCEPT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clear_ptr;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [DATA_W-1:0] mem [NPIX];

    logic              beat;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] wr_data;

    assign beat     = bus_valid & bus_ready;
    assign pix_addr = row * W_A + col;

    // Writes are suppressed in reset and on a restart cycle so a colliding beat is dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clear_ptr;
        wr_data = '0;
        if (rst && !frame_start) begin
            if (state == CLEAR) begin
                wr_en = 1'b1;
            end else if (state == ACCEPT && beat) begin
                wr_en   = 1'b1;
                wr_addr = pix_addr;
                wr_data = bus_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-first: the nonblocking write above lands after this sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= ({1'b0, rd_addr} < NPIX_A) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || frame_start) begin
            state      <= CLEAR;
            clear_ptr  <= '0;
            row        <= ONE;
            col        <= ONE;
            bus_ready  <= 1'b0;
            frame_done <= 1'b0;
            pix_count  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_ptr == LAST_PTR) begin
                        state     <= ACCEPT;
                        bus_ready <= 1'b1;
                    end else begin
                        clear_ptr <= clear_ptr + ONE;
                    end
                end
                ACCEPT: begin
                    if (beat) begin
                        pix_count <= pix_count + ONE;
                        if (col == COL_LAST) begin
                            col <= ONE;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                        if (row == ROW_LAST && col == COL_LAST) begin
                            state      <= DONE;
                            bus_ready  <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state     <= CLEAR;
                    clear_ptr <= '0;
                    bus_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_result_writer.sv
// Directed bench for sobel_result_writer on an 8x8 frame.
module tb_sobel_result_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_out;
    logic       bus_valid;
    logic       bus_ready;
    logic       frame_start;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done;
    logic [5:0] pix_count;

    int checks = 0;
    int errors = 0;
    int n;

    sobel_result_writer #(.IMG_W(8), .IMG_H(8), .DATA_W(8), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .frame_start(frame_start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = 6'(a);
        tick();
        rd_en = 1'b0;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    // Counts cycles until bus_ready rises, bounded so a stuck DUT still reaches the summary.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!bus_ready && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; bus_valid = 1'b0; bus_out = '0;
        frame_start = 1'b0; rd_en = 1'b0; rd_addr = '0;
        tick();
        tick();
        chk("rst_ready", 32'(bus_ready), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_count", 32'(pix_count), 32'd0);
        chk("rst_rdata", 32'(rd_data), 32'd0);

        // Frame 1: valid held high through reset release; 40 beats offered, 36 taken.
        rst = 1'b1; bus_valid = 1'b1; bus_out = 8'd1;
        wait_ready(n);
        chk("clear_len_rst", 32'(n), 32'd64);
        for (int k = 1; k <= 40; k++) begin
            bus_out = 8'(k);
            tick();
            if (k == 35) chk("done_before_last", 32'(frame_done), 32'd0);
            if (k == 36) begin
                chk("done_after_last", 32'(frame_done), 32'd1);
                chk("count_36", 32'(pix_count), 32'd36);
            end
        end
        bus_valid = 1'b0;
        chk("overflow_count", 32'(pix_count), 32'd36);
        chk("overflow_ready", 32'(bus_ready), 32'd0);
        chk("overflow_done", 32'(frame_done), 32'd1);

        // Full dump: border ring zero, interior pixel k at row 1+(k-1)/6, col 1+(k-1)%6.
        for (int a = 0; a < 64; a++) begin
            int r, c;
            logic [7:0] e;
            r = a / 8;
            c = a % 8;
            if (r == 0 || r == 7 || c == 0 || c == 7) e = 8'd0;
            else e = 8'((r - 1) * 6 + c);
            rd(a, e, "dump_f1");
        end
        rd(9, 8'd1, "f1_addr9");
        rd(14, 8'd6, "f1_addr14");
        rd(17, 8'd7, "f1_addr17");
        rd(54, 8'd36, "f1_addr54");
        rd_addr = 6'd9;
        tick();
        chk("rdata_hold", 32'(rd_data), 32'd36);

        // Restart: buffer cleared, addr 54 back to zero.
        pulse_start();
        chk("restart_done", 32'(frame_done), 32'd0);
        chk("restart_count", 32'(pix_count), 32'd0);
        wait_ready(n);
        chk("clear_len_restart", 32'(n), 32'd64);
        rd(54, 8'd0, "restart_addr54");

        // Throttled valid; junk data on idle cycles must never land.
        for (int k = 1; k <= 36; k++) begin
            bus_valid = 1'b1;
            bus_out   = (k % 2 == 1) ? 8'hA5 : 8'h5A;
            tick();
            bus_valid = 1'b0;
            bus_out   = 8'h33;
            tick();
            chk("thr_count", 32'(pix_count), 32'(k));
            if (k == 35) chk("thr_done_35", 32'(frame_done), 32'd0);
        end
        chk("thr_done", 32'(frame_done), 32'd1);
        rd(9, 8'hA5, "thr_addr9");
        rd(10, 8'h5A, "thr_addr10");
        rd(11, 8'hA5, "thr_addr11");
        rd(17, 8'hA5, "thr_addr17");
        rd(18, 8'h5A, "thr_addr18");
        rd(54, 8'h5A, "thr_addr54");
        rd(15, 8'h00, "thr_addr15");

        // Reset in the middle of a frame.
        pulse_start();
        wait_ready(n);
        chk("clear_len_mid", 32'(n), 32'd64);
        bus_valid = 1'b1;
        bus_out   = 8'h77;
        for (int k = 0; k < 10; k++) tick();
        bus_valid = 1'b0;
        chk("mid_count10", 32'(pix_count), 32'd10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_count", 32'(pix_count), 32'd0);
        chk("mid_rst_ready", 32'(bus_ready), 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        wait_ready(n);
        chk("clear_len_midrst", 32'(n), 32'd64);
        rd(9, 8'h00, "mid_addr9");
        rd(18, 8'h00, "mid_addr18");

        // Read/write collision on addr 9: read returns the pre-write value.
        bus_valid = 1'b1;
        bus_out   = 8'hFF;
        rd_en     = 1'b1;
        rd_addr   = 6'd9;
        tick();
        bus_valid = 1'b0;
        rd_en     = 1'b0;
        chk("collide_old", 32'(rd_data), 32'd0);
        chk("collide_count", 32'(pix_count), 32'd1);
        rd(9, 8'hFF, "collide_new");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
